// File: rtl/manipulador_vetores_stream.sv
// Streaming vector manipulator: per-word lane/bit rearrangement feeding a small
// output FIFO, with valid/ready handshakes on both the input and output sides.
module manipulador_vetores_stream #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [7:0]       rot_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] word_count
);

  localparam int LANES = WIDTH / LANE;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] xformed;
  int               rot;
  int               src;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;

  // Rotate-left by r lanes means output lane k takes input lane (k - r) mod LANES.
  always_comb begin
    xformed = in_data;
    rot     = int'(rot_amt) % LANES;
    src     = 0;
    case (mode)
      2'b01: begin
        for (int k = 0; k < LANES; k++)
          xformed[k*LANE +: LANE] = in_data[(LANES-1-k)*LANE +: LANE];
      end
      2'b10: begin
        for (int i = 0; i < WIDTH; i++)
          xformed[i] = in_data[WIDTH-1-i];
      end
      2'b11: begin
        for (int k = 0; k < LANES; k++) begin
          src = (k + LANES - rot) % LANES;
          xformed[k*LANE +: LANE] = in_data[src*LANE +: LANE];
        end
      end
      default: ;
    endcase
  end

  // Ready is held low during reset so nothing is offered a handshake while cleared.
  assign in_ready  = rst_n && (occ < OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      word_count <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        word_count <= word_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through out_data once occupied.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= xformed;
  end

endmodule
